temp_alert_irq_ctrl: RTL

//   Parametrised alert/interrupt controller for NUM_CH I2C temperature-sensor ALERT pins.

---
 rtl/temp_alert_irq_ctrl.sv | 91 +++++++++
 1 files changed

// File: rtl/temp_alert_irq_ctrl.sv
// Alert/interrupt controller for NUM_CH active-low temperature-sensor ALERT pins.
// Each channel: 2-flop sync, debounce filter, level/edge event, sticky pending, mask, registered INT.
module temp_alert_irq_ctrl #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] ALERT_N,
  input  logic [NUM_CH-1:0] EDGE_MODE,
  input  logic [NUM_CH-1:0] MASK,
  input  logic              CLR_STB,
  input  logic [NUM_CH-1:0] CLR_SEL,
  output logic [NUM_CH-1:0] PENDING,
  output logic [NUM_CH-1:0] MISSED,
  output logic [NUM_CH-1:0] INT,
  output logic              INT_ANY
);

  localparam int unsigned    CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [NUM_CH-1:0] s1_q, s2_q;
  logic [NUM_CH-1:0] filt_q, filt_d;
  logic [NUM_CH-1:0] filt_dly_q;
  logic [CW-1:0]     cnt_q [NUM_CH];
  logic [CW-1:0]     cnt_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] miss_q, miss_d;
  logic [NUM_CH-1:0] int_q, int_d;
  logic              int_any_q, int_any_d;

  logic [NUM_CH-1:0] active_s;
  logic [NUM_CH-1:0] clr;
  logic [NUM_CH-1:0] ev;

  always_comb begin
    active_s = ~s2_q;
    clr      = {NUM_CH{CLR_STB}} & CLR_SEL;
    // Edge mode only fires on the rising filtered level; level mode fires every active cycle.
    ev       = filt_q & (~EDGE_MODE | ~filt_dly_q);

    filt_d = filt_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = '0;
      if (active_s[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          filt_d[i] = active_s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    // A new event outranks a clear issued on the same cycle.
    pend_d    = ev | (pend_q & ~clr);
    miss_d    = (EDGE_MODE & ev & pend_q & ~clr) | (miss_q & ~clr);
    int_d     = pend_q & ~MASK;
    int_any_d = |int_d;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_q       <= '1;
      s2_q       <= '1;
      filt_q     <= '0;
      filt_dly_q <= '0;
      cnt_q      <= '{default: '0};
      pend_q     <= '0;
      miss_q     <= '0;
      int_q      <= '0;
      int_any_q  <= 1'b0;
    end else begin
      s1_q       <= ALERT_N;
      s2_q       <= s1_q;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      miss_q     <= miss_d;
      int_q      <= int_d;
      int_any_q  <= int_any_d;
    end
  end

  assign PENDING = pend_q;
  assign MISSED  = miss_q;
  assign INT     = int_q;
  assign INT_ANY = int_any_q;

endmodule
